vid_pattern_gen: RTL and testbench

Free-running video timing and test-pattern source that drives the 8-bit grayscale `pre_img_*` stream of the sharpening stage. It produces vsync/hsync/valid/data for a configurable raster (default 1280x720, 1650x750 total). It replaces file-driven stimulus for on-board bring-up and for closed-loop simulation of downstream filters.

---
 rtl/vid_pattern_gen.sv | 179 +++++++++++++++++
 tb/tb_vid_pattern_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_pattern_gen.sv
// ---------------------------------------------------------------------------
// vid_pattern_gen
//
// Free-running video timing and test-pattern source for the 8-bit grayscale
// pre_img_* stream of the sharpening stage. Produces vsync/hsync/valid/data
// for a configurable raster. The run request is honoured only at frame
// boundaries, so a frame that has started is always completed.
//
// Ports
//   clk          in   1   pixel clock
//   rst          in   1   asynchronous, active-high reset
//   en           in   1   run request, sampled in IDLE and at frame end
//   pattern_sel  in   2   0 h-ramp, 1 v-ramp, 2 32x32 checkerboard, 3 solid
//   solid_level  in   8   gray level for the solid pattern (sampled live)
//   img_vsync    out  1   active-high vsync
//   img_hsync    out  1   active-high hsync
//   img_valid    out  1   active-pixel qualifier
//   img_data     out  8   pixel value, 0 outside the active area
//   frame_cnt    out  16  completed-frame count, wraps 0xFFFF -> 0
//   frame_done   out  1   one-cycle pulse alongside the last pixel of a frame
//
// FSM states
//   state | meaning
//   IDLE  | counters parked at 0, all video outputs 0, waiting for en
//   RUN   | raster counters advancing, outputs follow the counter decode
//
// All outputs are registered: the pins at edge t+1 show the decode of the
// counter values held between edges t and t+1.
// ---------------------------------------------------------------------------
module vid_pattern_gen #(
  parameter int H_SYNC  = 40,
  parameter int H_BACK  = 220,
  parameter int H_DISP  = 1280,
  parameter int H_TOTAL = 1650,
  parameter int V_SYNC  = 5,
  parameter int V_BACK  = 20,
  parameter int V_DISP  = 720,
  parameter int V_TOTAL = 750,
  parameter int CNT_W   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  solid_level,
  output logic        img_vsync,
  output logic        img_hsync,
  output logic        img_valid,
  output logic [7:0]  img_data,
  output logic [15:0] frame_cnt,
  output logic        frame_done
);

  // Raster boundaries, pre-sized to the counter width.
  localparam logic [CNT_W-1:0] H_SYNC_C    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG_C = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END_C = CNT_W'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CNT_W-1:0] H_LAST_C    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_C    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_BEG_C = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_END_C = CNT_W'(V_SYNC + V_BACK + V_DISP);
  localparam logic [CNT_W-1:0] V_LAST_C    = CNT_W'(V_TOTAL - 1);

  // Only the low byte of x/y feeds any pattern, so the active-area offset
  // is subtracted in 8 bits; the low byte of a difference depends only on
  // the low bytes of its operands.
  localparam logic [7:0] H_OFF8 = 8'(H_SYNC + H_BACK);
  localparam logic [7:0] V_OFF8 = 8'(V_SYNC + V_BACK);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [1:0]       sel_q;

  // Counter decode
  logic       hs_d;
  logic       vs_d;
  logic       h_act;
  logic       v_act;
  logic       act_d;
  logic [7:0] x8;
  logic [7:0] y8;
  logic [7:0] pix;
  logic [7:0] data_d;
  logic       h_last;
  logic       v_last;
  logic       frame_end;

  always_comb begin
    hs_d      = (h_cnt < H_SYNC_C);
    vs_d      = (v_cnt < V_SYNC_C);
    h_act     = (h_cnt >= H_ACT_BEG_C) && (h_cnt < H_ACT_END_C);
    v_act     = (v_cnt >= V_ACT_BEG_C) && (v_cnt < V_ACT_END_C);
    act_d     = h_act && v_act;
    x8        = h_cnt[7:0] - H_OFF8;
    y8        = v_cnt[7:0] - V_OFF8;
    h_last    = (h_cnt == H_LAST_C);
    v_last    = (v_cnt == V_LAST_C);
    frame_end = h_last && v_last;

    pix = 8'h00;
    case (sel_q)
      2'd0:    pix = x8;
      2'd1:    pix = y8;
      // x[5]^y[5] flips every 32 pixels / lines.
      2'd2:    pix = (x8[5] ^ y8[5]) ? 8'hFF : 8'h00;
      default: pix = solid_level;
    endcase

    data_d = act_d ? pix : 8'h00;
  end

  // Sequencer, raster counters and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      h_cnt      <= '0;
      v_cnt      <= '0;
      sel_q      <= 2'd0;
      img_vsync  <= 1'b0;
      img_hsync  <= 1'b0;
      img_valid  <= 1'b0;
      img_data   <= 8'h00;
      frame_cnt  <= 16'h0000;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          h_cnt      <= '0;
          v_cnt      <= '0;
          img_vsync  <= 1'b0;
          img_hsync  <= 1'b0;
          img_valid  <= 1'b0;
          img_data   <= 8'h00;
          frame_done <= 1'b0;
          if (en) begin
            state <= RUN;
            sel_q <= pattern_sel;
          end
        end

        RUN: begin
          img_vsync  <= vs_d;
          img_hsync  <= hs_d;
          img_valid  <= act_d;
          img_data   <= data_d;
          frame_done <= frame_end;

          if (frame_end) begin
            // frame_cnt is written only here, so it holds between frames.
            frame_cnt <= frame_cnt + 16'd1;
            h_cnt     <= '0;
            v_cnt     <= '0;
            if (en) begin
              sel_q <= pattern_sel;
            end else begin
              state <= IDLE;
            end
          end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_cnt + 1'b1;
          end else begin
            h_cnt <= h_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
`timescale 1ns / 1ps
module tb_vid_pattern_gen;

  // Wide raster: 4+4+320+8 = 336 clocks/line, 2+2+36+2 = 42 lines.
  localparam int W_FRAME = 336 * 42;
  // Tall raster: 1+1+4+2 = 8 clocks/line, 2+2+260+2 = 266 lines.
  localparam int T_FRAME = 8 * 266;
  // Small raster: 2+2+8+4 = 16 clocks/line, 1+1+4+2 = 8 lines.
  localparam int S_FRAME = 16 * 8;

  logic        clk;
  logic        rst;
  logic [7:0]  solid;

  logic        w_en, t_en, s_en;
  logic [1:0]  w_sel, t_sel, s_sel;
  logic        w_vs, w_hs, w_val, w_fd;
  logic        t_vs, t_hs, t_val, t_fd;
  logic        s_vs, s_hs, s_val, s_fd;
  logic [7:0]  w_dat, t_dat, s_dat;
  logic [15:0] w_fc, t_fc, s_fc;

  int n_checks;
  int n_errors;

  vid_pattern_gen #(
    .H_SYNC(4), .H_BACK(4), .H_DISP(320), .H_TOTAL(336),
    .V_SYNC(2), .V_BACK(2), .V_DISP(36), .V_TOTAL(42), .CNT_W(11)
  ) u_wide (
    .clk(clk), .rst(rst), .en(w_en), .pattern_sel(w_sel), .solid_level(solid),
    .img_vsync(w_vs), .img_hsync(w_hs), .img_valid(w_val), .img_data(w_dat),
    .frame_cnt(w_fc), .frame_done(w_fd)
  );

  vid_pattern_gen #(
    .H_SYNC(1), .H_BACK(1), .H_DISP(4), .H_TOTAL(8),
    .V_SYNC(2), .V_BACK(2), .V_DISP(260), .V_TOTAL(266), .CNT_W(11)
  ) u_tall (
    .clk(clk), .rst(rst), .en(t_en), .pattern_sel(t_sel), .solid_level(solid),
    .img_vsync(t_vs), .img_hsync(t_hs), .img_valid(t_val), .img_data(t_dat),
    .frame_cnt(t_fc), .frame_done(t_fd)
  );

  vid_pattern_gen #(
    .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_TOTAL(16),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_TOTAL(8), .CNT_W(11)
  ) u_small (
    .clk(clk), .rst(rst), .en(s_en), .pattern_sel(s_sel), .solid_level(solid),
    .img_vsync(s_vs), .img_hsync(s_hs), .img_valid(s_val), .img_data(s_dat),
    .frame_cnt(s_fc), .frame_done(s_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream accumulator: one sample per clock, index 0 = first vsync sample.
  int         a_idx, a_hs, a_vs, a_val, a_fd, a_fd_idx, a_first;
  int         a_runs, a_bad_run, a_cur_run, a_run_len;
  int         a_blank_nz, a_ramp_bad, a_solid_bad, a_row, a_px;
  logic       a_prev_val;
  logic [7:0] c_x300_r0, c_0_0, c_32_0, c_32_32, c_0_3, c_0_257;

  task automatic acc_reset(input int run_len);
    a_idx = 0; a_hs = 0; a_vs = 0; a_val = 0; a_fd = 0; a_fd_idx = -1;
    a_first = -1; a_runs = 0; a_bad_run = 0; a_cur_run = 0; a_run_len = run_len;
    a_blank_nz = 0; a_ramp_bad = 0; a_solid_bad = 0; a_row = -1; a_px = 0;
    a_prev_val = 1'b0;
    c_x300_r0 = 8'hEE; c_0_0 = 8'hEE; c_32_0 = 8'hEE;
    c_32_32 = 8'hEE; c_0_3 = 8'hEE; c_0_257 = 8'hEE;
  endtask

  task automatic acc_sample(input logic vs, input logic hs, input logic val,
                            input logic [7:0] dat, input logic fd);
    if (hs) begin
      a_px = 0;
      a_hs++;
    end
    if (vs) a_vs++;
    if (fd) begin
      a_fd++;
      a_fd_idx = a_idx;
    end
    if (val) begin
      if (!a_prev_val) begin
        a_row++;
        if (a_first < 0) a_first = a_idx;
      end
      if (dat != a_px[7:0]) a_ramp_bad++;
      if (dat != 8'h5A) a_solid_bad++;
      if (a_row == 0   && a_px == 300) c_x300_r0 = dat;
      if (a_row == 0   && a_px == 0)   c_0_0     = dat;
      if (a_row == 0   && a_px == 32)  c_32_0    = dat;
      if (a_row == 32  && a_px == 32)  c_32_32   = dat;
      if (a_row == 3   && a_px == 0)   c_0_3     = dat;
      if (a_row == 257 && a_px == 0)   c_0_257   = dat;
      a_px++;
      a_cur_run++;
      a_val++;
    end else begin
      if (dat != 8'h00) a_blank_nz++;
      if (a_prev_val) begin
        a_runs++;
        if (a_cur_run != a_run_len) a_bad_run++;
        a_cur_run = 0;
      end
    end
    a_prev_val = val;
    a_idx++;
  endtask

  task automatic wide_window(input int sel_at, input logic [1:0] sel_val, input int drop_at);
    acc_reset(320);
    for (int i = 0; i < W_FRAME; i++) begin
      acc_sample(w_vs, w_hs, w_val, w_dat, w_fd);
      if (i == sel_at)  w_sel = sel_val;
      if (i == drop_at) w_en  = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic small_window(input int n, input int sel_at, input logic [1:0] sel_val,
                              input int drop_at);
    acc_reset(8);
    for (int i = 0; i < n; i++) begin
      acc_sample(s_vs, s_hs, s_val, s_dat, s_fd);
      if (i == sel_at)  s_sel = sel_val;
      if (i == drop_at) s_en  = 1'b0;
      @(negedge clk);
    end
  endtask

  logic [31:0] ored;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    solid = 8'h5A;
    w_en = 1'b0; t_en = 1'b0; s_en = 1'b0;
    w_sel = 2'd0; t_sel = 2'd0; s_sel = 2'd0;

    // Reset held with en high and a toggling selector: everything stays 0.
    w_en = 1'b1;
    ored = '0;
    for (int i = 0; i < 8; i++) begin
      w_sel = 2'(i);
      @(negedge clk);
      ored = ored | 32'({w_vs, w_hs, w_val, w_dat, w_fd}) | 32'(w_fc)
                  | 32'({t_vs, t_hs, t_val, t_dat, t_fd}) | 32'(t_fc)
                  | 32'({s_vs, s_hs, s_val, s_dat, s_fd}) | 32'(s_fc);
    end
    check("rst_hold_outputs", ored, 32'd0);

    // Start-up latency: RUN after one edge, vsync/hsync after the second.
    w_sel = 2'd0;
    rst   = 1'b0;
    @(negedge clk);
    check("start_vs_lat1", 32'(w_vs), 32'd0);
    @(negedge clk);
    check("start_vs", 32'(w_vs), 32'd1);
    check("start_hs", 32'(w_hs), 32'd1);

    // Async reset in the middle of the first active line.
    repeat (1362) @(negedge clk);
    check("pre_rst_valid", 32'(w_val), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(w_val), 32'd0);
    check("rst_async_data", 32'(w_dat), 32'd0);
    check("rst_async_vs_hs", 32'({w_vs, w_hs}), 32'd0);
    check("rst_frame_cnt", 32'(w_fc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("restart_after_rst_vs", 32'(w_vs), 32'd1);

    // Frame A: horizontal ramp; selector changed to checkerboard mid-frame.
    wide_window(W_FRAME / 2, 2'd2, -1);
    check("wA_hsync_clocks", a_hs, 168);
    check("wA_vsync_clocks", a_vs, 672);
    check("wA_valid_total", a_val, 11520);
    check("wA_active_lines", a_runs, 36);
    check("wA_bad_line_len", a_bad_run, 0);
    check("wA_first_valid_idx", a_first, 1352);
    check("wA_frame_done_cnt", a_fd, 1);
    check("wA_frame_done_idx", a_fd_idx, W_FRAME - 1);
    check("wA_blank_data", a_blank_nz, 0);
    check("wA_ramp_all", a_ramp_bad, 0);
    check("wA_x300", 32'(c_x300_r0), 32'h2C);
    check("wA_frame_cnt", 32'(w_fc), 32'd1);
    check("wA_no_gap_vs", 32'(w_vs), 32'd1);

    // Frame B: checkerboard; selector changed to solid mid-frame.
    wide_window(W_FRAME / 2, 2'd3, -1);
    check("wB_chk_0_0", 32'(c_0_0), 32'h00);
    check("wB_chk_32_0", 32'(c_32_0), 32'hFF);
    check("wB_chk_32_32", 32'(c_32_32), 32'h00);
    check("wB_frame_cnt", 32'(w_fc), 32'd2);

    // Frame C: solid 0x5A; en dropped mid-frame, frame still completes.
    wide_window(-1, 2'd0, W_FRAME / 2);
    check("wC_solid_all", a_solid_bad, 0);
    check("wC_valid_total", a_val, 11520);
    check("wC_blank_data", a_blank_nz, 0);
    check("wC_frame_done_cnt", a_fd, 1);
    check("wC_idle_outputs", 32'({w_vs, w_hs, w_val, w_dat, w_fd}), 32'd0);
    check("wC_frame_cnt", 32'(w_fc), 32'd3);

    // Tall raster: vertical ramp reaching row 257.
    t_sel = 2'd1;
    t_en  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t_start_vs", 32'(t_vs), 32'd1);
    t_en = 1'b0;
    acc_reset(4);
    for (int i = 0; i < T_FRAME; i++) begin
      acc_sample(t_vs, t_hs, t_val, t_dat, t_fd);
      @(negedge clk);
    end
    check("t_active_lines", a_row + 1, 260);
    check("t_row3", 32'(c_0_3), 32'h03);
    check("t_row257", 32'(c_0_257), 32'h01);
    check("t_frame_done_cnt", a_fd, 1);
    check("t_frame_cnt", 32'(t_fc), 32'd1);

    // Small raster: selector latch 0 -> 3 mid-frame.
    s_sel = 2'd0;
    s_en  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("s_start_vs", 32'(s_vs), 32'd1);
    small_window(S_FRAME, 48, 2'd3, -1);
    check("s1_ramp_kept", a_ramp_bad, 0);
    check("s1_valid_total", a_val, 32);
    check("s1_frame_cnt", 32'(s_fc), 32'd1);
    small_window(S_FRAME, -1, 2'd3, -1);
    check("s2_solid_all", a_solid_bad, 0);
    check("s2_valid_total", a_val, 32);
    check("s2_frame_cnt", 32'(s_fc), 32'd2);

    // Enable dropped at line 2: frame completes, then outputs go quiet.
    small_window(S_FRAME, -1, 2'd3, 40);
    check("s3_frame_done_cnt", a_fd, 1);
    check("s3_frame_done_idx", a_fd_idx, S_FRAME - 1);
    check("s3_valid_total", a_val, 32);
    ored = '0;
    for (int i = 0; i < 4; i++) begin
      ored = ored | 32'({s_vs, s_hs, s_val, s_dat, s_fd});
      @(negedge clk);
    end
    check("s3_idle_outputs", ored, 32'd0);
    check("s3_frame_cnt", 32'(s_fc), 32'd3);

    // Re-raise en: same 2-clock start-up latency.
    s_en = 1'b1;
    @(negedge clk);
    check("s_reraise_lat1", 32'(s_vs), 32'd0);
    @(negedge clk);
    check("s_reraise_vs", 32'(s_vs), 32'd1);

    // frame_cnt wrap from 0xFFFF.
    force u_small.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release u_small.frame_cnt;
    small_window(S_FRAME - 1, -1, 2'd3, 0);
    check("wrap_frame_done", a_fd, 1);
    check("wrap_frame_cnt", 32'(s_fc), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
